// File: rtl/data_memory_arbiter_pkg.sv
// Shared types and helpers for the two-port SPRAM data-memory arbiter.
// Holds the FSM state encoding, read-owner tag and byte-enable to nibble-mask mapping.
package data_memory_arbiter_pkg;

  typedef enum logic {
    PRIO_A  = 1'b0,
    FORCE_B = 1'b1
  } arb_state_t;

  typedef enum logic {
    OWNER_A = 1'b0,
    OWNER_B = 1'b1
  } rd_owner_t;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned MASK_W = 4;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  // Each byte covers two SPRAM nibbles; result is {msw_mask, lsw_mask}.
  function automatic logic [2*MASK_W-1:0] be_to_nibble_mask(input logic [BE_W-1:0] be);
    return {be[3], be[3], be[2], be[2], be[1], be[1], be[0], be[0]};
  endfunction

endpackage

// File: rtl/data_memory_arbiter_if.sv
// One requester port of the data-memory arbiter (CPU or debug/loader side).
// The requester uses the master modport, the arbiter the slave modport.
interface data_memory_arbiter_if
  import data_memory_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 14
);

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [BE_W-1:0]   be;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata, be,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/data_memory_arbiter_rr_counter.sv
// dmem_rr_counter: saturating starvation counter with synchronous clear.
// Clear takes priority over increment.
module dmem_rr_counter
  import data_memory_arbiter_pkg::*;
#(
  parameter int unsigned MAX   = 4,
  parameter int unsigned CNT_W = cnt_width(MAX)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != MAX_V)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/data_memory_arbiter.sv
// Two-port arbiter in front of a 32-bit SPRAM pair, port A priority with starvation guard.
// Define DMEM_BYTE_MASK_EN to honour byte enables as nibble write masks.
module data_memory_arbiter
  import data_memory_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 14,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  data_memory_arbiter_if.slave  a,
  data_memory_arbiter_if.slave  b,
  output logic                  mem_cs,
  output logic                  mem_wren,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [MASK_W-1:0]     mem_mask_msw,
  output logic [MASK_W-1:0]     mem_mask_lsw,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam int unsigned       CNT_W       = cnt_width(STARVE_MAX);
  localparam logic [CNT_W-1:0]  STARVE_LAST = CNT_W'(STARVE_MAX - 1);

  arb_state_t        state_q, state_d;
  logic [CNT_W-1:0]  starve_cnt;
  logic              cnt_inc, cnt_clr;
  logic              a_gnt, b_gnt;

  logic              rd_valid_q, rd_valid_d;
  rd_owner_t         rd_owner_q, rd_owner_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
  logic              a_rvalid, b_rvalid;

  dmem_rr_counter #(
    .MAX   (STARVE_MAX),
    .CNT_W (CNT_W)
  ) u_starve (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .count (starve_cnt)
  );

  // Grants are suppressed while reset is high so every output reads low during reset.
  always_comb begin
    state_d = state_q;
    a_gnt   = 1'b0;
    b_gnt   = 1'b0;
    cnt_inc = 1'b0;
    cnt_clr = 1'b0;
    if (!reset) begin
      unique case (state_q)
        PRIO_A: begin
          a_gnt = a.req;
          b_gnt = b.req & ~a.req;
          if (a_gnt && b.req) begin
            cnt_inc = 1'b1;
            if (starve_cnt >= STARVE_LAST) begin
              state_d = FORCE_B;
            end
          end else begin
            cnt_clr = 1'b1;
          end
        end
        FORCE_B: begin
          b_gnt   = b.req;
          a_gnt   = a.req & ~b.req;
          cnt_clr = 1'b1;
          if (b_gnt || !b.req) begin
            state_d = PRIO_A;
          end
        end
        default: state_d = PRIO_A;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= PRIO_A;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    mem_cs    = 1'b0;
    mem_wren  = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (a_gnt) begin
      mem_cs    = 1'b1;
      mem_wren  = a.we;
      mem_addr  = a.addr;
      mem_wdata = a.wdata;
    end else if (b_gnt) begin
      mem_cs    = 1'b1;
      mem_wren  = b.we;
      mem_addr  = b.addr;
      mem_wdata = b.wdata;
    end
  end

`ifdef DMEM_BYTE_MASK_EN
  logic [BE_W-1:0] sel_be;

  always_comb begin
    sel_be = '0;
    if (a_gnt) begin
      sel_be = a.be;
    end else if (b_gnt) begin
      sel_be = b.be;
    end
  end

  // Reads keep full masks; only writes are narrowed by the byte enables.
  always_comb begin
    {mem_mask_msw, mem_mask_lsw} = '0;
    if (mem_cs) begin
      {mem_mask_msw, mem_mask_lsw} = mem_wren ? be_to_nibble_mask(sel_be) : '1;
    end
  end
`else
  always_comb begin
    {mem_mask_msw, mem_mask_lsw} = '0;
    if (mem_cs) begin
      {mem_mask_msw, mem_mask_lsw} = '1;
    end
  end
`endif

  // SPRAM data arrives one cycle after the granted read; the owner bit steers it.
  always_comb begin
    rd_valid_d = mem_cs & ~mem_wren;
    rd_owner_d = b_gnt ? OWNER_B : OWNER_A;
    a_rvalid   = ~reset & rd_valid_q & (rd_owner_q == OWNER_A);
    b_rvalid   = ~reset & rd_valid_q & (rd_owner_q == OWNER_B);
    a_rdata_d  = a_rvalid ? mem_rdata : a_rdata_q;
    b_rdata_d  = b_rvalid ? mem_rdata : b_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      rd_owner_q <= OWNER_A;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_owner_q <= rd_owner_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
    end
  end

  assign a.gnt    = a_gnt;
  assign b.gnt    = b_gnt;
  assign a.rvalid = a_rvalid;
  assign b.rvalid = b_rvalid;
  assign a.rdata  = reset ? '0 : (a_rvalid ? mem_rdata : a_rdata_q);
  assign b.rdata  = reset ? '0 : (b_rvalid ? mem_rdata : b_rdata_q);

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench for data_memory_arbiter with a behavioural nibble-masked SPRAM model.
// Expected byte-write result follows DMEM_BYTE_MASK_EN.
module tb_data_memory_arbiter;
  import data_memory_arbiter_pkg::*;

  localparam int unsigned ADDR_W = 14;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_cs, mem_wren;
  logic [13:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_mask_msw, mem_mask_lsw;
  logic [31:0] mem_rdata = '0;

  logic        pl_en;
  logic [13:0] pl_addr;
  logic [31:0] pl_data;
  logic [31:0] sram [0:16383];

  int checks = 0;
  int errors = 0;

  data_memory_arbiter_if #(.ADDR_W(ADDR_W)) a_if ();
  data_memory_arbiter_if #(.ADDR_W(ADDR_W)) b_if ();

  data_memory_arbiter #(
    .ADDR_W     (ADDR_W),
    .STARVE_MAX (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .a            (a_if),
    .b            (b_if),
    .mem_cs       (mem_cs),
    .mem_wren     (mem_wren),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_mask_msw (mem_mask_msw),
    .mem_mask_lsw (mem_mask_lsw),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pl_en) begin
      sram[pl_addr] <= pl_data;
    end else if (mem_cs) begin
      if (mem_wren) begin
        for (int i = 0; i < 4; i++) begin
          if (mem_mask_lsw[i]) sram[mem_addr][4*i +: 4] <= mem_wdata[4*i +: 4];
          if (mem_mask_msw[i]) sram[mem_addr][16+4*i +: 4] <= mem_wdata[16+4*i +: 4];
        end
      end else begin
        mem_rdata <= sram[mem_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_a(input logic req, input logic we, input logic [13:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
    a_if.req = req; a_if.we = we; a_if.addr = addr; a_if.wdata = wdata; a_if.be = be;
  endtask

  task automatic drive_b(input logic req, input logic we, input logic [13:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
    b_if.req = req; b_if.we = we; b_if.addr = addr; b_if.wdata = wdata; b_if.be = be;
  endtask

  task automatic preload(input logic [13:0] addr, input logic [31:0] data);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = addr; pl_data = data;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] exp_bw;
    logic [7:0]  exp_wmask;
    logic [1:0]  exp_gnt [0:5];
`ifdef DMEM_BYTE_MASK_EN
    exp_bw    = 32'h1122AB44;
    exp_wmask = 8'h0C;
`else
    exp_bw    = 32'h0000AB00;
    exp_wmask = 8'hFF;
`endif
    exp_gnt[0] = 2'b10; exp_gnt[1] = 2'b10; exp_gnt[2] = 2'b10;
    exp_gnt[3] = 2'b10; exp_gnt[4] = 2'b01; exp_gnt[5] = 2'b10;

    reset = 1'b1;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    drive_a(1'b1, 1'b1, 14'h0030, 32'hFFFF_FFFF, 4'hF);
    drive_b(1'b0, 1'b0, '0, '0, '0);

    // Reset state: a request during reset must not reach the memory
    @(negedge clk); #1;
    chk("rst_gnt",    {a_if.gnt, b_if.gnt}, 2'b00);
    chk("rst_mem",    {mem_cs, mem_wren, mem_addr, mem_mask_msw, mem_mask_lsw}, '0);
    chk("rst_wdata",  mem_wdata, 32'h0);
    chk("rst_rvalid", {a_if.rvalid, b_if.rvalid}, 2'b00);
    chk("rst_rdata",  {a_if.rdata, b_if.rdata}, 64'h0);

    preload(14'h0010, 32'hDEADBEEF);
    preload(14'h0020, 32'h11223344);
    preload(14'h0001, 32'h000000A1);
    preload(14'h0002, 32'h000000B2);
    @(negedge clk);
    pl_en = 1'b0; reset = 1'b0;
    drive_a(1'b0, 1'b0, '0, '0, '0);

    // Single read
    @(negedge clk);
    drive_a(1'b1, 1'b0, 14'h0010, '0, '0); #1;
    chk("rd_gnt",   {a_if.gnt, b_if.gnt}, 2'b10);
    chk("rd_mem",   {mem_cs, mem_wren, mem_addr}, {2'b10, 14'h0010});
    chk("rd_mask",  {mem_mask_msw, mem_mask_lsw}, 8'hFF);
    @(negedge clk);
    drive_a(1'b0, 1'b0, '0, '0, '0); #1;
    chk("rd_rvalid", {a_if.rvalid, b_if.rvalid}, 2'b10);
    chk("rd_rdata",  a_if.rdata, 32'hDEADBEEF);
    @(negedge clk); #1;
    chk("rd_pulse", a_if.rvalid, 1'b0);
    chk("rd_hold",  a_if.rdata, 32'hDEADBEEF);

    // Byte write then read back
    @(negedge clk);
    drive_a(1'b1, 1'b1, 14'h0020, 32'h0000AB00, 4'b0010); #1;
    chk("bw_mem",   {a_if.gnt, mem_cs, mem_wren, mem_wdata}, {3'b111, 32'h0000AB00});
    chk("bw_mask",  {mem_mask_msw, mem_mask_lsw}, exp_wmask);
    @(negedge clk);
    drive_a(1'b0, 1'b0, '0, '0, '0); #1;
    chk("bw_norv",  {a_if.rvalid, b_if.rvalid}, 2'b00);
    @(negedge clk);
    drive_a(1'b1, 1'b0, 14'h0020, '0, '0);
    @(negedge clk);
    drive_a(1'b0, 1'b0, '0, '0, '0); #1;
    chk("bw_rdata", {a_if.rvalid, a_if.rdata}, {1'b1, exp_bw});

    // Alternating reads A then B
    @(negedge clk);
    chk("alt_b_init", b_if.rdata, 32'h0);
    drive_a(1'b1, 1'b0, 14'h0001, '0, '0); #1;
    chk("alt_a_gnt", {a_if.gnt, b_if.gnt}, 2'b10);
    @(negedge clk);
    drive_a(1'b0, 1'b0, '0, '0, '0);
    drive_b(1'b1, 1'b0, 14'h0002, '0, '0); #1;
    chk("alt_b_gnt", {a_if.gnt, b_if.gnt}, 2'b01);
    chk("alt_a_rv",  {a_if.rvalid, b_if.rvalid, a_if.rdata}, {2'b10, 32'hA1});
    @(negedge clk);
    drive_b(1'b0, 1'b0, '0, '0, '0); #1;
    chk("alt_b_rv",  {a_if.rvalid, b_if.rvalid, b_if.rdata}, {2'b01, 32'hB2});
    chk("alt_a_hold", a_if.rdata, 32'hA1);

    // Conflict: four A grants, one B grant, then A again
    @(negedge clk);
    drive_a(1'b1, 1'b0, 14'h0001, '0, '0);
    drive_b(1'b1, 1'b0, 14'h0002, '0, '0);
    for (int c = 0; c < 6; c++) begin
      #1;
      chk($sformatf("conf_c%0d", c + 1), {a_if.gnt, b_if.gnt}, exp_gnt[c]);
      if (c == 5) chk("conf_b_rv", {b_if.rvalid, b_if.rdata}, {1'b1, 32'hB2});
      @(negedge clk);
    end
    drive_a(1'b0, 1'b0, '0, '0, '0);
    drive_b(1'b0, 1'b0, '0, '0, '0);

    // Reset mid-operation after a granted B read
    @(negedge clk);
    drive_b(1'b1, 1'b0, 14'h0002, '0, '0); #1;
    chk("mr_b_gnt", b_if.gnt, 1'b1);
    @(negedge clk);
    drive_b(1'b0, 1'b0, '0, '0, '0);
    drive_a(1'b1, 1'b1, 14'h0030, 32'h12345678, 4'hF);
    reset = 1'b1; #1;
    chk("mr_ctl",   {a_if.gnt, b_if.gnt, a_if.rvalid, b_if.rvalid, mem_cs, mem_wren}, 6'b0);
    chk("mr_bus",   {mem_addr, mem_mask_msw, mem_mask_lsw}, '0);
    chk("mr_wdata", mem_wdata, 32'h0);
    chk("mr_rdata", {a_if.rdata, b_if.rdata}, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    drive_a(1'b0, 1'b0, '0, '0, '0); #1;
    chk("mr_b_rv", b_if.rvalid, 1'b0);
    chk("mr_state", 64'(dut.state_q), 64'(PRIO_A));
    chk("mr_count", 64'(dut.u_starve.count_q), 64'h0);

    // Reset clears a partly-run starvation count
    @(negedge clk);
    drive_a(1'b1, 1'b0, 14'h0001, '0, '0);
    drive_b(1'b1, 1'b0, 14'h0002, '0, '0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("rcnt_c%0d", c + 1), {a_if.gnt, b_if.gnt}, exp_gnt[c]);
      @(negedge clk);
    end
    drive_a(1'b0, 1'b0, '0, '0, '0);
    drive_b(1'b0, 1'b0, '0, '0, '0);

    // Idle
    @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      chk($sformatf("idle_c%0d", c), {mem_cs, mem_wren, a_if.rvalid, b_if.rvalid}, 4'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
